// File: rtl/jtag_tap_master.sv
// Host-side JTAG TAP master: expands TAP-reset / IR-scan / DR-scan / idle-clock
// commands into TCK/TMS/TDI bit sequences and returns the TDO bits captured while shifting.
module jtag_tap_master #(
   parameter int CLK_DIV = 4,
   parameter int IR_MAX  = 10,
   parameter int DR_MAX  = 38
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [5:0]        cmd_len,
   input  logic [DR_MAX-1:0] cmd_data,
   output logic              rsp_valid,
   output logic [DR_MAX-1:0] rsp_data,
   output logic              busy,
   output logic              tck,
   output logic              tms,
   output logic              tdi,
   input  logic              tdo
);

   // Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready;
   // rsp_valid is a single-cycle pulse with no back-pressure.
   typedef enum logic [1:0] {IDLE, PRE_TLR, RUN, DONE} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [5:0]        len_q, len_d;
   logic [DR_MAX-1:0] data_q, data_d;
   logic [DR_MAX-1:0] cap_q, cap_d;
   logic [6:0]        idx_q, idx_d;
   logic [7:0]        div_q, div_d;
   logic              tck_q, tck_d;
   logic              tms_q, tms_d;
   logic              tdi_q, tdi_d;
   logic              tap_known_q, tap_known_d;

   logic [5:0]        len_in;
   logic              tlr_in;
   logic              phase_tlr;

   // Bit offset of the first shift bit inside an IR/DR sequence.
   function automatic logic [6:0] seq_pre(input logic [1:0] op);
      case (op)
         2'b01:   return 7'd4;
         2'b10:   return 7'd3;
         default: return 7'd0;
      endcase
   endfunction

   function automatic logic [6:0] seq_total(input logic [1:0] op, input logic [5:0] len,
                                            input logic tlr);
      if (tlr) return 7'd6;
      case (op)
         2'b00:   return 7'd6;
         2'b01:   return 7'd6 + {1'b0, len};
         2'b10:   return 7'd5 + {1'b0, len};
         default: return {1'b0, len};
      endcase
   endfunction

   function automatic logic seq_shift(input logic [1:0] op, input logic [5:0] len,
                                      input logic tlr, input logic [6:0] idx);
      return !tlr && (op == 2'b01 || op == 2'b10) &&
             (idx >= seq_pre(op)) && (idx < seq_pre(op) + {1'b0, len});
   endfunction

   function automatic logic seq_tms(input logic [1:0] op, input logic [5:0] len,
                                    input logic tlr, input logic [6:0] idx);
      logic [6:0] pre;
      logic [6:0] stop;
      pre  = seq_pre(op);
      stop = pre + {1'b0, len};
      if (tlr || op == 2'b00) return idx != 7'd5;
      if (op == 2'b11) return 1'b0;
      if (idx < pre) return (op == 2'b01) ? (idx < 7'd2) : (idx == 7'd0);
      if (idx < stop) return idx == stop - 7'd1;
      return idx == stop;
   endfunction

   function automatic logic seq_tdi(input logic [1:0] op, input logic [5:0] len,
                                    input logic tlr, input logic [6:0] idx,
                                    input logic [DR_MAX-1:0] data);
      if (!seq_shift(op, len, tlr, idx)) return 1'b0;
      return data[6'(idx - seq_pre(op))];
   endfunction

   always_comb begin
      len_in = (cmd_len == 6'd0) ? 6'd1 : cmd_len;
      if (cmd_op == 2'b01 && len_in > 6'(IR_MAX)) len_in = 6'(IR_MAX);
      if (cmd_op == 2'b10 && len_in > 6'(DR_MAX)) len_in = 6'(DR_MAX);
   end

   assign tlr_in    = (cmd_op != 2'b00) && !tap_known_q;
   assign phase_tlr = (state_q == PRE_TLR);

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      len_d       = len_q;
      data_d      = data_q;
      cap_d       = cap_q;
      idx_d       = idx_q;
      div_d       = div_q;
      tck_d       = tck_q;
      tms_d       = tms_q;
      tdi_d       = tdi_q;
      tap_known_d = tap_known_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               op_d    = cmd_op;
               len_d   = len_in;
               data_d  = cmd_data;
               cap_d   = '0;
               idx_d   = 7'd0;
               div_d   = 8'd0;
               state_d = tlr_in ? PRE_TLR : RUN;
               tms_d   = seq_tms(cmd_op, len_in, tlr_in, 7'd0);
               tdi_d   = seq_tdi(cmd_op, len_in, tlr_in, 7'd0, cmd_data);
            end
         end
         PRE_TLR, RUN: begin
            div_d = div_q + 8'd1;
            if (div_q == DIV_LAST) begin
               div_d = 8'd0;
               if (!tck_q) begin
                  tck_d = 1'b1;
                  if (seq_shift(op_q, len_q, phase_tlr, idx_q))
                     cap_d[6'(idx_q - seq_pre(op_q))] = tdo;
               end else begin
                  tck_d = 1'b0;
                  if (idx_q == seq_total(op_q, len_q, phase_tlr) - 7'd1) begin
                     if (phase_tlr) begin
                        // Inserted reset done; the real command starts at its bit 0.
                        state_d     = RUN;
                        tap_known_d = 1'b1;
                        idx_d       = 7'd0;
                        tms_d       = seq_tms(op_q, len_q, 1'b0, 7'd0);
                        tdi_d       = seq_tdi(op_q, len_q, 1'b0, 7'd0, data_q);
                     end else begin
                        state_d = DONE;
                        tdi_d   = 1'b0;
                        if (op_q == 2'b00) tap_known_d = 1'b1;
                     end
                  end else begin
                     idx_d = idx_q + 7'd1;
                     tms_d = seq_tms(op_q, len_q, phase_tlr, idx_q + 7'd1);
                     tdi_d = seq_tdi(op_q, len_q, phase_tlr, idx_q + 7'd1, data_q);
                  end
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         op_q        <= 2'b00;
         len_q       <= 6'd0;
         data_q      <= '0;
         cap_q       <= '0;
         idx_q       <= 7'd0;
         div_q       <= 8'd0;
         tck_q       <= 1'b0;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b0;
         tap_known_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         len_q       <= len_d;
         data_q      <= data_d;
         cap_q       <= cap_d;
         idx_q       <= idx_d;
         div_q       <= div_d;
         tck_q       <= tck_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
         tap_known_q <= tap_known_d;
      end
   end

   // cmd_ready is masked by reset so it reads 0 while reset is held.
   assign cmd_ready = (state_q == IDLE) && !reset;
   assign busy      = (state_q != IDLE);
   assign rsp_valid = (state_q == DONE);
   assign rsp_data  = cap_q;
   assign tck       = tck_q;
   assign tms       = tms_q;
   assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_tap_master.sv
// Bench for jtag_tap_master: a JTAG target model on the pins, a spec-level model of the
// expected TMS stream / response / latency, and a scoreboard monitor checking each rsp_valid.
module tb_jtag_tap_master;
  localparam int CLK_DIV = 4;
  localparam int IR_MAX  = 10;
  localparam int DR_MAX  = 38;
  localparam int W       = 38;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [5:0]   cmd_len = 6'd0;
  logic [W-1:0] cmd_data = '0;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         busy, tck, tms, tdi, tdo;

  jtag_tap_master #(.CLK_DIV(CLK_DIV), .IR_MAX(IR_MAX), .DR_MAX(DR_MAX)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  // Second instance at CLK_DIV=2 for the held-valid back-to-back check.
  logic         d2_reset = 1'b1;
  logic         d2_valid = 1'b0;
  logic         d2_ready, d2_rsp_valid, d2_busy, d2_tck, d2_tms, d2_tdi;
  logic [W-1:0] d2_rsp_data;
  logic [W-1:0] d2_data = '0;
  logic         d2_tdo = 1'b0;

  jtag_tap_master #(.CLK_DIV(2), .IR_MAX(IR_MAX), .DR_MAX(DR_MAX)) u_dut2 (
    .clk(clk), .reset(d2_reset), .cmd_valid(d2_valid), .cmd_ready(d2_ready),
    .cmd_op(2'b00), .cmd_len(6'd0), .cmd_data(d2_data), .rsp_valid(d2_rsp_valid),
    .rsp_data(d2_rsp_data), .busy(d2_busy), .tck(d2_tck), .tms(d2_tms), .tdi(d2_tdi),
    .tdo(d2_tdo)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- JTAG target model ----------------
  typedef enum int {T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDR,
                    T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR} tap_t;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      T_TLR:   return m ? T_TLR   : T_RTI;
      T_RTI:   return m ? T_SELDR : T_RTI;
      T_SELDR: return m ? T_SELIR : T_CAPDR;
      T_CAPDR: return m ? T_EX1DR : T_SHDR;
      T_SHDR:  return m ? T_EX1DR : T_SHDR;
      T_EX1DR: return m ? T_UPDR  : T_PADR;
      T_PADR:  return m ? T_EX2DR : T_PADR;
      T_EX2DR: return m ? T_UPDR  : T_SHDR;
      T_UPDR:  return m ? T_SELDR : T_RTI;
      T_SELIR: return m ? T_TLR   : T_CAPIR;
      T_CAPIR: return m ? T_EX1IR : T_SHIR;
      T_SHIR:  return m ? T_EX1IR : T_SHIR;
      T_EX1IR: return m ? T_UPIR  : T_PAIR;
      T_PAIR:  return m ? T_EX2IR : T_PAIR;
      T_EX2IR: return m ? T_UPIR  : T_SHIR;
      T_UPIR:  return m ? T_SELDR : T_RTI;
      default: return T_TLR;
    endcase
  endfunction

  tap_t         tgt_st = T_TLR;
  logic [W-1:0] dr_cap = '0, ir_cap = '0, shin = '0, dr_upd = '0, ir_upd = '0;
  int           sh_cnt = 0;
  bit           loopback = 1'b0;
  logic         lb_q = 1'b0;

  always @(posedge tck) begin
    case (tgt_st)
      T_CAPDR, T_CAPIR: begin sh_cnt = 0; shin = '0; end
      T_SHDR, T_SHIR: begin
        if (sh_cnt < W) shin[sh_cnt] = tdi;
        sh_cnt++;
      end
      T_UPDR: dr_upd = shin;
      T_UPIR: ir_upd = shin;
      default: ;
    endcase
    lb_q = tdi;
    tgt_st = tap_next(tgt_st, tms);
  end

  assign tdo = loopback ? lb_q :
               (tgt_st == T_SHDR && sh_cnt < W) ? dr_cap[sh_cnt] :
               (tgt_st == T_SHIR && sh_cnt < W) ? ir_cap[sh_cnt] : 1'b0;

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   exp_upd_q[$];
  logic [127:0]   exp_tms_q[$];
  int             exp_n_q[$];
  int             exp_kind_q[$];
  bit             model_known = 1'b0;

  task automatic wait_ready();
    int b = 0;
    while (!cmd_ready && b < 2000) begin @(negedge clk); b++; end
    if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [W-1:0] data);
    int l;
    bit tq[$];
    logic [127:0] t;
    logic [W-1:0] mask, rsp;
    int kind;
    int b;
    l = (len == 0) ? 1 : int'(len);
    if (op == 2'b01 && l > IR_MAX) l = IR_MAX;
    if (op == 2'b10 && l > DR_MAX) l = DR_MAX;
    if (op != 2'b00 && !model_known) tq = {1, 1, 1, 1, 1, 0};
    case (op)
      2'b00: tq = {tq, 1, 1, 1, 1, 1, 0};
      2'b01, 2'b10: begin
        if (op == 2'b01) tq = {tq, 1, 1, 0, 0}; else tq = {tq, 1, 0, 0};
        for (int i = 0; i < l; i++) tq.push_back(i == l - 1);
        tq = {tq, 1, 0};
      end
      default: for (int i = 0; i < l; i++) tq.push_back(1'b0);
    endcase
    t = '0;
    foreach (tq[i]) t[i] = tq[i];
    mask = (l >= W) ? {W{1'b1}} : ((W'(1) << l) - W'(1));
    if (op == 2'b01) rsp = ir_cap & mask;
    else if (op == 2'b10) rsp = loopback ? ((data << 1) & mask) : (dr_cap & mask);
    else rsp = '0;
    kind = loopback ? 0 : (op == 2'b01 ? 1 : (op == 2'b10 ? 2 : 0));
    model_known = 1'b1;

    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
    exp_q.push_back(rsp); exp_upd_q.push_back(data & mask);
    exp_tms_q.push_back(t); exp_n_q.push_back(tq.size()); exp_kind_q.push_back(kind);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_len = 6'($urandom); cmd_data = W'({$urandom, $urandom});
    b = 0;
    while (exp_q.size() != 0 && b < 5000) begin @(negedge clk); b++; end
    if (exp_q.size() != 0) begin
      check("rsp_timeout", 0, 1);
      exp_q.delete(); exp_upd_q.delete(); exp_tms_q.delete(); exp_n_q.delete(); exp_kind_q.delete();
    end
  endtask

  // Monitor: acceptance is seen as busy rising; TMS is recorded at every TCK rise.
  int           acc_cyc = 0;
  int           obs_n = 0;
  logic [127:0] obs_tms = '0;
  logic         busy_prev = 1'b0, tck_prev = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] e_rsp, e_upd;
    logic [127:0] e_tms;
    int e_n, e_kind;
    if (busy && !busy_prev) begin
      acc_cyc = cyc - 1; obs_n = 0; obs_tms = '0;
    end
    if (tck && !tck_prev) begin
      if (obs_n < 128) obs_tms[obs_n] = tms;
      obs_n++;
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) check("unexpected_rsp_valid", 1, 0);
      else begin
        e_rsp = exp_q.pop_front(); e_upd = exp_upd_q.pop_front(); e_tms = exp_tms_q.pop_front();
        e_n = exp_n_q.pop_front(); e_kind = exp_kind_q.pop_front();
        check("rsp_data", rsp_data, e_rsp);
        check("latency", cyc - acc_cyc, 2 * CLK_DIV * e_n + 1);
        check("tck_count", obs_n, e_n);
        check("tms_sequence", obs_tms, e_tms);
        check("busy_in_done", busy, 1);
        check("target_end_rti", tgt_st == T_RTI, 1);
        if (e_kind == 1) check("ir_update", ir_upd, e_upd);
        if (e_kind == 2) check("dr_update", dr_upd, e_upd);
      end
    end
    busy_prev = busy;
    tck_prev = tck;
  end

  task automatic abort_dr_scan();
    int rises = 0;
    int b = 0;
    logic tp = 1'b0;
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 6'd38; cmd_data = W'({$urandom, $urandom});
    @(negedge clk);
    cmd_valid = 1'b0;
    while (rises < 10 && b < 2000) begin
      @(negedge clk); b++;
      if (tck && !tp) rises++;
      tp = tck;
    end
    check("abort_reached_10th_tck", rises, 10);
    reset = 1'b1;
    @(negedge clk);
    check("abort_tck", tck, 0);
    check("abort_tms", tms, 1);
    check("abort_busy", busy, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_cmd_ready", cmd_ready, 0);
    reset = 1'b0;
    model_known = 1'b0;
    tgt_st = T_TLR;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    int d2_acc, d2_rsp, n_rsp, b;
    logic d2_busy_prev;

    repeat (3) @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_tck", tck, 0);
    check("reset_tms", tms, 1);
    check("reset_tdi", tdi, 0);
    check("reset_busy", busy, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);

    loopback = 1'b1;
    issue(2'b10, 6'd8, W'(8'hA5));
    loopback = 1'b0;
    ir_cap = W'(10'h155);
    issue(2'b01, 6'd2, W'(2'b10));
    dr_cap = 38'h12_3456_789A;
    issue(2'b10, 6'd38, 38'h3F_0000_0001);
    r = {$urandom, $urandom};
    issue(2'b10, 6'd50, r[W-1:0]);
    issue(2'b11, 6'd0, '1);
    abort_dr_scan();
    r = {$urandom, $urandom};
    issue(2'b10, 6'd12, r[W-1:0]);

    for (int i = 0; i < 12; i++) begin
      r = {$urandom, $urandom};
      dr_cap = r[W-1:0];
      ir_cap = W'($urandom_range(0, 1023));
      r = {$urandom, $urandom};
      issue(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), r[W-1:0]);
    end

    // Held cmd_valid at CLK_DIV=2 with op 00: 6 TCKs, latency 2*2*6+1.
    d2_acc = 0; d2_rsp = -1; n_rsp = 0; b = 0; d2_busy_prev = 1'b0;
    d2_reset = 1'b0;
    d2_valid = 1'b1;
    while (n_rsp < 4 && b < 400) begin
      @(negedge clk); b++;
      if (d2_busy && !d2_busy_prev) begin
        d2_acc = cyc - 1;
        if (d2_rsp >= 0) check("d2_accept_after_rsp", d2_acc, d2_rsp + 1);
      end
      if (d2_rsp_valid) begin
        n_rsp++;
        check("d2_latency", cyc - d2_acc, 25);
        check("d2_rsp_data", d2_rsp_data, 0);
        check("d2_ready_low_in_done", d2_ready, 0);
        d2_rsp = cyc;
      end
      d2_busy_prev = d2_busy;
    end
    d2_valid = 1'b0;
    check("d2_rsp_count", n_rsp, 4);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
